// File: rtl/wash_panel_ctrl.sv
// ============================================================================
//  wash_panel_ctrl : front-panel debounce, door interlock, run request and
//                    program-scaled phase duration for the wash phase FSM.
//  Rev 1.0
// ============================================================================
`default_nettype none

module wash_panel_ctrl #(
  parameter int          DEBOUNCE_CYCLES = 8,
  parameter int          DUR_WIDTH       = 32,
  parameter int unsigned FILL_T          = 1000000,
  parameter int unsigned WASH_T          = 1000000,
  parameter int unsigned RINSE_T         = 1000000,
  parameter int unsigned SPIN_T          = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_start_raw,
  input  logic                 btn_stop_raw,
  input  logic                 door_closed_raw,
  input  logic [1:0]           prog_sel,
  input  logic [1:0]           fsm_state,
  input  logic                 cycle_done,
  output logic                 run_req,
  output logic [DUR_WIDTH-1:0] duration,
  output logic                 door_lock,
  output logic [1:0]           prog_latched,
  output logic                 fault
);

  localparam int              CW      = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam int              XW      = DUR_WIDTH + 2;

  typedef enum logic [1:0] {
    P_IDLE  = 2'd0,
    P_RUN   = 2'd1,
    P_PAUSE = 2'd2,
    P_FAULT = 2'd3
  } state_t;

  // Bit order for all conditioning vectors: {door, stop, start}.
  logic [2:0] meta_q, sync_q, clean_prev_q;
  logic [2:0] clean_w;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q       <= 3'b000;
      sync_q       <= 3'b000;
      clean_prev_q <= 3'b000;
    end else begin
      meta_q       <= {door_closed_raw, btn_stop_raw, btn_start_raw};
      sync_q       <= meta_q;
      clean_prev_q <= clean_w;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_deb
      logic [CW-1:0] cnt_q;
      logic          clean_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_q   <= '0;
          clean_q <= 1'b0;
        end else if (sync_q[gi] == clean_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
          cnt_q   <= '0;
          clean_q <= sync_q[gi];
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      assign clean_w[gi] = clean_q;
    end
  endgenerate

  logic start_ev_w, stop_ev_w, door_closed_w;

  assign start_ev_w    = clean_w[0] & ~clean_prev_q[0];
  assign stop_ev_w     = clean_w[1] & ~clean_prev_q[1];
  assign door_closed_w = clean_w[2];

  state_t                 state_q, state_d;
  logic [1:0]             prog_latched_q, prog_latched_d;
  logic                   run_req_q, door_lock_q, fault_q;
  logic [DUR_WIDTH-1:0]   duration_q, duration_d;

  // Door-open is checked as a level so an open door during PAUSE also faults.
  always_comb begin
    state_d        = state_q;
    prog_latched_d = prog_latched_q;
    case (state_q)
      P_IDLE: begin
        if (start_ev_w && door_closed_w) begin
          state_d        = P_RUN;
          prog_latched_d = (prog_sel == 2'd3) ? 2'd1 : prog_sel;
        end
      end
      P_RUN: begin
        if (!door_closed_w)  state_d = P_FAULT;
        else if (stop_ev_w)  state_d = P_PAUSE;
        else if (cycle_done) state_d = P_IDLE;
      end
      P_PAUSE: begin
        if (!door_closed_w)  state_d = P_FAULT;
        else if (stop_ev_w)  state_d = P_IDLE;
        else if (start_ev_w) state_d = P_RUN;
      end
      P_FAULT: begin
        if (stop_ev_w && door_closed_w) state_d = P_IDLE;
      end
      default: state_d = P_IDLE;
    endcase
  end

  logic [XW-1:0] base_w, scaled_w;

  always_comb begin
    case (fsm_state)
      2'd0:    base_w = XW'(FILL_T);
      2'd1:    base_w = XW'(WASH_T);
      2'd2:    base_w = XW'(RINSE_T);
      default: base_w = XW'(SPIN_T);
    endcase
    case (prog_latched_q)
      2'd1:    scaled_w = base_w << 1;
      2'd2:    scaled_w = base_w + (base_w << 1);
      default: scaled_w = base_w;
    endcase
    duration_d = (|scaled_w[XW-1:DUR_WIDTH]) ? '1 : scaled_w[DUR_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= P_IDLE;
      prog_latched_q <= 2'd0;
      run_req_q      <= 1'b0;
      door_lock_q    <= 1'b0;
      fault_q        <= 1'b0;
      duration_q     <= '0;
    end else begin
      state_q        <= state_d;
      prog_latched_q <= prog_latched_d;
      run_req_q      <= (state_d == P_RUN);
      door_lock_q    <= (state_d == P_RUN) || (state_d == P_PAUSE);
      fault_q        <= (state_d == P_FAULT);
      duration_q     <= duration_d;
    end
  end

  assign run_req      = run_req_q;
  assign door_lock    = door_lock_q;
  assign fault        = fault_q;
  assign prog_latched = prog_latched_q;
  assign duration     = duration_q;

endmodule

`default_nettype wire

// File: tb/tb_wash_panel_ctrl.sv
// ============================================================================
//  tb_wash_panel_ctrl : scenario and randomized checks of wash_panel_ctrl.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_wash_panel_ctrl;

  localparam int D = 8;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_FAULT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_start = 1'b0, btn_stop = 1'b0, door = 1'b0, cycle_done = 1'b0;
  logic [1:0]  prog_sel = 2'd0, fsm_state = 2'd0;

  logic        run_req, door_lock, fault;
  logic [1:0]  prog_latched;
  logic [31:0] duration;
  logic        run21, lock21, fault21;
  logic [1:0]  prog21;
  logic [20:0] dur21;

  int n_chk = 0;
  int n_fail = 0;

  int         mode = M_IDLE;
  logic [1:0] m_prog = 2'd0;
  bit         m_door = 1'b0;

  always #5 clk = ~clk;

  wash_panel_ctrl #(
    .DEBOUNCE_CYCLES(D), .DUR_WIDTH(32),
    .FILL_T(123456), .WASH_T(1000000), .RINSE_T(654321), .SPIN_T(2000000)
  ) dut (
    .clk(clk), .rst(rst), .btn_start_raw(btn_start), .btn_stop_raw(btn_stop),
    .door_closed_raw(door), .prog_sel(prog_sel), .fsm_state(fsm_state),
    .cycle_done(cycle_done), .run_req(run_req), .duration(duration),
    .door_lock(door_lock), .prog_latched(prog_latched), .fault(fault)
  );

  wash_panel_ctrl #(
    .DEBOUNCE_CYCLES(D), .DUR_WIDTH(21),
    .FILL_T(300000), .WASH_T(1000000), .RINSE_T(500000), .SPIN_T(1000000)
  ) dut21 (
    .clk(clk), .rst(rst), .btn_start_raw(btn_start), .btn_stop_raw(btn_stop),
    .door_closed_raw(door), .prog_sel(prog_sel), .fsm_state(fsm_state),
    .cycle_done(cycle_done), .run_req(run21), .duration(dur21),
    .door_lock(lock21), .prog_latched(prog21), .fault(fault21)
  );

  // Expected {run_req, door_lock, fault, prog_latched} from the abstract mode.
  function automatic logic [4:0] exp_ctl();
    return {mode == M_RUN, (mode == M_RUN) || (mode == M_PAUSE), mode == M_FAULT, m_prog};
  endfunction

  function automatic longint unsigned exp_dur(input logic [1:0] st, input logic [1:0] p,
                                              input bit narrow);
    longint unsigned b, v, lim;
    if (narrow) begin
      case (st)
        2'd0: b = 300000; 2'd1: b = 1000000; 2'd2: b = 500000; default: b = 1000000;
      endcase
      lim = (64'd1 << 21) - 1;
    end else begin
      case (st)
        2'd0: b = 123456; 2'd1: b = 1000000; 2'd2: b = 654321; default: b = 2000000;
      endcase
      lim = (64'd1 << 32) - 1;
    end
    v = b * (longint'(p) + 1);
    return (v > lim) ? lim : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic model_start();
    if (mode == M_IDLE && m_door) begin
      mode   = M_RUN;
      m_prog = (prog_sel == 2'd3) ? 2'd1 : prog_sel;
    end else if (mode == M_PAUSE && m_door) begin
      mode = M_RUN;
    end
  endtask

  task automatic model_stop();
    if (mode == M_RUN)                 mode = M_PAUSE;
    else if (mode == M_PAUSE)          mode = M_IDLE;
    else if (mode == M_FAULT && m_door) mode = M_IDLE;
  endtask

  task automatic press(input bit is_stop);
    if (is_stop) btn_stop = 1'b1; else btn_start = 1'b1;
    settle(D + 6);
    btn_stop = 1'b0;
    btn_start = 1'b0;
    settle(D + 6);
    if (is_stop) model_stop(); else model_start();
  endtask

  task automatic set_door(input bit v);
    door = v;
    settle(D + 6);
    m_door = v;
    if (!v && (mode == M_RUN || mode == M_PAUSE)) mode = M_FAULT;
  endtask

  task automatic pulse_done();
    cycle_done = 1'b1;
    tick();
    cycle_done = 1'b0;
    if (mode == M_RUN) mode = M_IDLE;
  endtask

  task automatic test_reset();
    logic [4:0] got;
    rst = 1'b0;
    #23;
    got = {run_req, door_lock, fault, prog_latched};
    n_chk++;
    if (got !== 5'b0) begin n_fail++; $display("FAIL reset_ctl got=%b exp=00000", got); end
    n_chk++;
    if (duration !== 32'd0 || dur21 !== 21'd0) begin
      n_fail++; $display("FAIL reset_dur got=%0d/%0d exp=0/0", duration, dur21);
    end
    tick();
    rst = 1'b1;
    set_door(1'b1);
  endtask

  task automatic test_glitch();
    int k;
    for (int i = 0; i < 3; i++) begin
      k = $urandom_range(1, D - 3);
      btn_start = 1'b1;
      settle(k);
      btn_start = 1'b0;
      settle(D + 4);
      n_chk++;
      if ({run_req, door_lock, fault, prog_latched} !== exp_ctl()) begin
        n_fail++;
        $display("FAIL glitch_%0d len=%0d got=%b exp=%b", i, k,
                 {run_req, door_lock, fault, prog_latched}, exp_ctl());
      end
    end
  endtask

  task automatic test_debounce();
    prog_sel = 2'd2;
    btn_start = 1'b1;
    settle(D + 2);
    n_chk++;
    if (run_req !== 1'b0) begin n_fail++; $display("FAIL deb_early run_req got=%b exp=0", run_req); end
    tick();
    n_chk++;
    if (run_req !== 1'b1 || door_lock !== 1'b1) begin
      n_fail++; $display("FAIL deb_edge run/lock got=%b%b exp=11", run_req, door_lock);
    end
    settle(5);
    btn_start = 1'b0;
    settle(D + 6);
    model_start();
    n_chk++;
    if (prog_latched !== 2'd2) begin n_fail++; $display("FAIL deb_prog got=%0d exp=2", prog_latched); end
    fsm_state = 2'd1;
    tick();
    n_chk++;
    if (duration !== 32'd3000000 || dur21 !== 21'd2097151) begin
      n_fail++; $display("FAIL dur_wash_heavy got=%0d/%0d exp=3000000/2097151", duration, dur21);
    end
    fsm_state = 2'd3;
    tick();
    n_chk++;
    if (duration !== 32'd6000000 || dur21 !== 21'd2097151) begin
      n_fail++; $display("FAIL dur_spin_sat got=%0d/%0d exp=6000000/2097151", duration, dur21);
    end
    prog_sel = 2'd0;
    settle(4);
    n_chk++;
    if (prog_latched !== 2'd2) begin n_fail++; $display("FAIL prog_hold got=%0d exp=2", prog_latched); end
  endtask

  task automatic test_cycle_done();
    pulse_done();
    n_chk++;
    if (run_req !== 1'b0 || door_lock !== 1'b0) begin
      n_fail++; $display("FAIL cycle_done run/lock got=%b%b exp=00", run_req, door_lock);
    end
  endtask

  task automatic test_interlock();
    set_door(1'b0);
    press(1'b0);
    n_chk++;
    if ({run_req, door_lock, fault, prog_latched} !== exp_ctl()) begin
      n_fail++; $display("FAIL interlock got=%b exp=%b", {run_req, door_lock, fault, prog_latched}, exp_ctl());
    end
    set_door(1'b1);
  endtask

  task automatic test_fault();
    prog_sel = 2'd1;
    press(1'b0);
    set_door(1'b0);
    n_chk++;
    if ({fault, run_req, door_lock} !== 3'b100) begin
      n_fail++; $display("FAIL fault_enter got=%b exp=100", {fault, run_req, door_lock});
    end
    press(1'b1);
    n_chk++;
    if (fault !== 1'b1) begin n_fail++; $display("FAIL fault_stop_open got=%b exp=1", fault); end
    set_door(1'b1);
    press(1'b1);
    n_chk++;
    if ({run_req, door_lock, fault, prog_latched} !== exp_ctl() || fault !== 1'b0) begin
      n_fail++; $display("FAIL fault_exit got=%b exp=%b", {run_req, door_lock, fault, prog_latched}, exp_ctl());
    end
  endtask

  task automatic test_pause();
    press(1'b0);
    press(1'b1);
    n_chk++;
    if ({run_req, door_lock} !== 2'b01) begin
      n_fail++; $display("FAIL pause got=%b%b exp=01", run_req, door_lock);
    end
    press(1'b0);
    n_chk++;
    if (run_req !== 1'b1) begin n_fail++; $display("FAIL resume got=%b exp=1", run_req); end
    press(1'b1);
    press(1'b1);
    n_chk++;
    if ({run_req, door_lock, fault} !== 3'b000) begin
      n_fail++; $display("FAIL pause_idle got=%b exp=000", {run_req, door_lock, fault});
    end
  endtask

  task automatic test_priority();
    press(1'b0);
    btn_stop = 1'b1;
    settle(D + 2);
    cycle_done = 1'b1;
    tick();
    cycle_done = 1'b0;
    settle(4);
    btn_stop = 1'b0;
    settle(D + 6);
    model_stop();
    n_chk++;
    if ({run_req, door_lock, fault} !== 3'b010) begin
      n_fail++; $display("FAIL stop_vs_done got=%b exp=010", {run_req, door_lock, fault});
    end
    press(1'b1);
    n_chk++;
    if (door_lock !== 1'b0) begin n_fail++; $display("FAIL prio_unlock got=%b exp=0", door_lock); end
  endtask

  task automatic test_prog3();
    prog_sel = 2'd3;
    press(1'b0);
    n_chk++;
    if (prog_latched !== 2'd1) begin n_fail++; $display("FAIL prog3 got=%0d exp=1", prog_latched); end
    pulse_done();
  endtask

  task automatic test_reset_midrun();
    prog_sel = 2'd2;
    press(1'b0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    n_chk++;
    if ({run_req, door_lock, fault, prog_latched} !== 5'b0 || duration !== 32'd0) begin
      n_fail++; $display("FAIL async_reset got=%b dur=%0d exp=00000 dur=0",
                         {run_req, door_lock, fault, prog_latched}, duration);
    end
    tick();
    rst = 1'b1;
    mode = M_IDLE;
    m_prog = 2'd0;
    settle(D + 6);
    n_chk++;
    if ({run_req, door_lock, fault, prog_latched} !== exp_ctl()) begin
      n_fail++; $display("FAIL post_reset got=%b exp=%b", {run_req, door_lock, fault, prog_latched}, exp_ctl());
    end
  endtask

  task automatic test_random();
    int  r, k;
    for (int i = 0; i < 40; i++) begin
      prog_sel = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 4);
      case (r)
        0: press(1'b0);
        1: press(1'b1);
        2: set_door(!m_door);
        3: pulse_done();
        default: begin
          k = $urandom_range(1, D - 3);
          btn_stop = 1'b1;
          settle(k);
          btn_stop = 1'b0;
          settle(D + 4);
        end
      endcase
      fsm_state = 2'($urandom_range(0, 3));
      settle(2);
      n_chk++;
      if ({run_req, door_lock, fault, prog_latched} !== exp_ctl()) begin
        n_fail++; $display("FAIL rnd_ctl_%0d op=%0d got=%b exp=%b", i, r,
                           {run_req, door_lock, fault, prog_latched}, exp_ctl());
      end
      n_chk++;
      if (duration !== 32'(exp_dur(fsm_state, m_prog, 1'b0)) ||
          dur21 !== 21'(exp_dur(fsm_state, m_prog, 1'b1))) begin
        n_fail++; $display("FAIL rnd_dur_%0d st=%0d got=%0d/%0d exp=%0d/%0d", i, fsm_state,
                           duration, dur21, exp_dur(fsm_state, m_prog, 1'b0),
                           exp_dur(fsm_state, m_prog, 1'b1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_debounce();
    test_cycle_done();
    test_interlock();
    test_fault();
    test_pause();
    test_priority();
    test_prog3();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
